memory_bank_32b: RTL
====================

# memory_bank_32b

Word-addressed scratchpad that answers the request stream of a CGRA memory port. It accepts `addr`, `to_mem` and `write_rq` from the port and returns read data on `from_mem` one cycle later. A host-side valid/ready port fills and drains the bank when the CGRA is not running. After reset, a clear sequence zero-fills the array before any access is accepted.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, 16..4096.
- `ADDR_W`, log2(DEPTH): index width; derived, do not override.

- `Clock`  in  1  single clock for all logic.
- `Reset`  in  1  synchronous, active-high.
- `Enable`  in  1  1 = CGRA owns the bank; 0 = host owns it.
- `addr`  in  32  CGRA word address.
- `to_mem`  in  32  CGRA write data.
- `write_rq`  in  1  CGRA write strobe; 0 means read.
- `from_mem`  out  32  CGRA read data, registered.
- `host_valid`  in  1  host request valid.
- `host_ready`  out  1  host request accepted this cycle.
- `host_we`  in  1  host write (1) / read (0).
- `host_addr`  in  ADDR_W  host word index.
- `host_wdata`  in  32  host write data.
- `host_rdata`  out  32  host read data, registered.
- `host_rvalid`  out  1  host_rdata valid, one-cycle pulse.
- `busy`  out  1  clear sequence in progress.
- `range_err`  out  1  sticky; a CGRA access fell outside DEPTH.
- `wr_count`  out  16  CGRA writes performed; saturates at 16'hFFFF.

## Operation
- FSM has two states: CLEAR and RUN. `Reset` forces CLEAR with the clear index at 0.
- CLEAR: writes 0 to word[idx] and increments idx each cycle. After idx = DEPTH-1 it moves to RUN, so CLEAR takes exactly DEPTH cycles. `busy`=1, `host_ready`=0, and all CGRA and host requests are ignored (no memory effect, no counter effect).
- RUN with `Enable`=1 serves one CGRA access every cycle:
  - The access is in range when `addr[31:ADDR_W]`==0; the index is `addr[ADDR_W-1:0]`.
  - `write_rq`=1, in range: word[index] <= `to_mem`; `wr_count` += 1 (saturating).
  - `write_rq`=0, in range: `from_mem` <= word[index] on the next edge.
  - Out of range: the write is dropped, a read returns 0, and `range_err` <= 1.
  - `host_ready`=0.
- RUN with `Enable`=0:
  - `host_ready`=1. A transfer occurs when `host_valid` && `host_ready`.
  - Host write: word[`host_addr`] <= `host_wdata`.
  - Host read: `host_rdata` <= word, and `host_rvalid`=1 on the next cycle only.
  - CGRA inputs are ignored and `from_mem` holds its last value.
- Memory is single-port: at most one access per cycle. `Enable` selects the owner, so there is no arbitration.
- `range_err` and `wr_count` clear only on `Reset`.

## Timing
- Values after `Reset`: `from_mem`=0, `host_rdata`=0, `host_rvalid`=0, `host_ready`=0, `busy`=1, `range_err`=0, `wr_count`=0.
- `host_ready` is a registered or state-decoded signal. It does not depend combinationally on `host_valid`.
- First accepted access is in cycle DEPTH after `Reset` deasserts; cycle 0 is the first cycle with `Reset` low.
- Read latency is one cycle on both ports. A read issued in cycle N is visible in cycle N+1.
- A write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- A CGRA read and a host read never overlap, because `Enable` selects one owner.
- An `Enable` toggle takes effect in the same cycle. A host read accepted in cycle N still produces `host_rvalid` in N+1, even if `Enable` rises in N+1.
- `Reset` during RUN aborts all activity and restarts CLEAR. Data written before the reset is lost, and any pending `host_rvalid` is suppressed.
- `wr_count` saturates: at 16'hFFFF, further writes still write memory but the count holds.

## Test plan
- Clear sequence, DEPTH=16: release `Reset` -> `busy`=1 for exactly 16 cycles and `host_ready`=0 throughout; then `busy`=0. Reading every index returns 0.
- Host fill/drain: `Enable`=0; write word[i] = 32'hA5000000+i for all i; read them back -> each `host_rdata` matches and `host_rvalid` pulses exactly once per read, one cycle after acceptance.
- CGRA stream: `Enable`=1; write `addr`=3, `to_mem`=32'hDEADBEEF, then read `addr`=3 the next cycle -> `from_mem`=32'hDEADBEEF one cycle later; `wr_count`=1.
- Out of range: `addr`=DEPTH+2 with `write_rq`=1, then a read of the same address -> memory unchanged, read returns 0, `range_err`=1 and stays 1; `wr_count` unchanged.
- Ownership: with `Enable`=1, assert `host_valid` -> `host_ready`=0 and no memory change. With `Enable`=0, toggle CGRA `write_rq` -> no write occurs and `from_mem` holds.
- Reset mid-run: write nonzero data, assert `Reset` for 1 cycle during a host read -> `host_rvalid` suppressed, `busy`=1 for DEPTH cycles, then all words read 0.

Source files
------------

// File: rtl/memory_bank_32b_if.sv
// rtl/memory_bank_32b_if.sv - CGRA memory-port and host-port bundle for memory_bank_32b
interface memory_bank_32b_if #(
  parameter int ADDR_W = 8
);
  logic              i_enable;
  logic [31:0]       i_addr;
  logic [31:0]       i_to_mem;
  logic              i_write_rq;
  logic [31:0]       o_from_mem;
  logic              i_host_valid;
  logic              o_host_ready;
  logic              i_host_we;
  logic [ADDR_W-1:0] i_host_addr;
  logic [31:0]       i_host_wdata;
  logic [31:0]       o_host_rdata;
  logic              o_host_rvalid;
  logic              o_busy;
  logic              o_range_err;
  logic [15:0]       o_wr_count;

  modport master (
    output i_enable, i_addr, i_to_mem, i_write_rq,
    output i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    input  o_from_mem, o_host_ready, o_host_rdata, o_host_rvalid,
    input  o_busy, o_range_err, o_wr_count
  );

  modport slave (
    input  i_enable, i_addr, i_to_mem, i_write_rq,
    input  i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    output o_from_mem, o_host_ready, o_host_rdata, o_host_rvalid,
    output o_busy, o_range_err, o_wr_count
  );
endinterface

// File: rtl/memory_bank_32b.sv
// rtl/memory_bank_32b.sv - single-port 32-bit scratchpad shared by a CGRA port and a host port
module memory_bank_32b #(
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  memory_bank_32b_if.slave   bus
);
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_from_mem;
  logic [31:0]       r_host_rdata;
  logic              r_host_rvalid;
  logic              r_range_err;
  logic [15:0]       r_wr_count;

  logic              w_run, w_cgra, w_host, w_in_range;
  logic              w_cgra_wr, w_cgra_rd, w_host_wr, w_host_rd;
  logic [ADDR_W-1:0] w_cgra_idx;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0]       w_mem_wdata;

  assign w_run      = (r_state == S_RUN);
  assign w_cgra     = w_run && bus.i_enable;
  assign w_host     = w_run && !bus.i_enable;
  assign w_in_range = ((bus.i_addr >> ADDR_W) == 32'd0);
  assign w_cgra_idx = bus.i_addr[ADDR_W-1:0];
  assign w_cgra_wr  = w_cgra && bus.i_write_rq && w_in_range;
  assign w_cgra_rd  = w_cgra && !bus.i_write_rq;
  assign w_host_wr  = w_host && bus.i_host_valid && bus.i_host_we;
  assign w_host_rd  = w_host && bus.i_host_valid && !bus.i_host_we;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_CLEAR: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == ADDR_W'(DEPTH - 1)) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Enable picks the single owner of the write port, so this mux never collides.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_idx;
    w_mem_wdata = 32'd0;
    if (!i_reset) begin
      if (!w_run) begin
        w_mem_we = 1'b1;
      end else if (w_cgra_wr) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = w_cgra_idx;
        w_mem_wdata = bus.i_to_mem;
      end else if (w_host_wr) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = bus.i_host_addr;
        w_mem_wdata = bus.i_host_wdata;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_from_mem    <= 32'd0;
      r_host_rdata  <= 32'd0;
      r_host_rvalid <= 1'b0;
      r_range_err   <= 1'b0;
      r_wr_count    <= 16'd0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) r_host_rdata <= r_mem[bus.i_host_addr];
      if (w_cgra_rd) r_from_mem <= w_in_range ? r_mem[w_cgra_idx] : 32'd0;
      if (w_cgra && !w_in_range) r_range_err <= 1'b1;
      if (w_cgra_wr && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign bus.o_from_mem    = r_from_mem;
  assign bus.o_host_ready  = w_host;
  assign bus.o_host_rdata  = r_host_rdata;
  assign bus.o_host_rvalid = r_host_rvalid;
  assign bus.o_busy        = !w_run;
  assign bus.o_range_err   = r_range_err;
  assign bus.o_wr_count    = r_wr_count;
endmodule
